codec_ctrl_arbiter: RTL
=======================

Name: codec_ctrl_arbiter

Overview:
Parametrised multi-requester front end for the CODEC register sequencer, sitting between NUM_REQ requesters and i2c_seq_sm. Requester 0 is the init unit; the others are user or debug ports.
- Arbitrates requesters round-robin; init_active restricts grants to requester 0.
- Issues one register transaction at a time to the sequencer.
- Retries a transaction on missed ACK, aborts it on timeout.
- Returns per-requester done/error/read-data, and keeps saturating retry and error statistics.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_W, 8, register address width
DATA_W, 8, register data width
MAX_RETRY, 3, re-issues allowed after missed ACK (0 = none)
START_TO, 16, cycles allowed for seq_busy to rise after issue
TIMEOUT_CYC, 1000000, max cycles from issue to completion

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
init_active  in  1  when high only requester 0 is eligible
req_rd_en  in  NUM_REQ  per-requester read request (level)
req_wr_en  in  NUM_REQ  per-requester write request (level)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_accept  out  NUM_REQ  one-cycle pulse: request captured
req_done  out  NUM_REQ  one-cycle completion pulse
req_error  out  NUM_REQ  valid with req_done: transaction failed
req_rdata  out  DATA_W  read data, shared by all requesters
req_rdata_valid  out  NUM_REQ  pulse with req_done on successful read
seq_rd_en  out  1  one-cycle read strobe to sequencer
seq_wr_en  out  1  one-cycle write strobe to sequencer
seq_addr  out  ADDR_W  held from issue until completion
seq_wdata  out  DATA_W  held from issue until completion
seq_rdata  in  DATA_W  sequencer read data
seq_rdata_valid  in  1  sequencer read data strobe
seq_busy  in  1  sequencer busy
seq_missed_ack  in  1  sampled at completion
busy  out  1  high in every state except IDLE
stat_retry_cnt  out  16  saturating retry count
stat_error_cnt  out  16  saturating failed-transaction count

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0; counters = 0.
- Reset asserted mid-transaction takes effect immediately. No abort is sent to the sequencer.
- Requests are levels. Each requester holds rd/wr, addr and wdata until it sees req_accept.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE: if any eligible request, grant the first requester at or after pointer+1 (mod NUM_REQ). Capture its op/addr/wdata, then go to ISSUE.
- ISSUE (1 cycle):
  - Pulse req_accept[g] on the first issue only.
  - Pulse seq_rd_en or seq_wr_en.
  - Load the timeout counter on the first issue only; set the start counter.
  - Go to WAIT_START.
- rd and wr both high at capture: no sequencer strobe. Go from ISSUE straight to RESP with error=1; req_accept is still pulsed.
- WAIT_START:
  - seq_busy high -> WAIT_DONE.
  - START_TO cycles elapse with seq_busy low -> RESP, error=1.
- WAIT_DONE:
  - seq_rdata_valid captures seq_rdata.
  - Completion is the first cycle with seq_busy low.
  - missed_ack and retries < MAX_RETRY: increment retry count and stat_retry_cnt, then ISSUE again.
  - missed_ack and retries exhausted: error.
  - No missed_ack: success.
- Timeout counter runs from the first issue through WAIT_START and WAIT_DONE. Reaching TIMEOUT_CYC -> RESP, error=1, no retry.
- RESP (1 cycle):
  - Pulse req_done[g] and req_error[g].
  - On a successful read, also pulse req_rdata_valid[g] and drive req_rdata (held until the next read completes).
  - On error, increment stat_error_cnt.
  - Set pointer = g; return to IDLE.
- Arbitration resumes the cycle after RESP, so at most one transaction is outstanding.
- Latency: request seen in IDLE at cycle N -> accept and seq strobe at N+1; done = completion cycle + 1.
- init_active falling while a transaction is in flight: that transaction completes normally.
- A request dropped before accept is simply not granted.
- Counters hold at 16'hFFFF.

Decomposition:
- Package codec_ctrl_pkg: state enum, op enum (OP_RD, OP_WR, OP_BAD), counter width constant.
- Sub-module rr_arbiter (NUM_REQ): request vector, eligibility mask and pointer in; one-hot grant and index out; purely combinational.

Test Plan:
- Single write, req1 addr 8'h04 data 8'h5A -> seq_wr_en at N+1 with addr 04/data 5A; busy held 10 cycles -> req_done[1]=1, req_error=0.
- Read: seq_rdata 8'hC3 valid during busy -> req_rdata=C3, req_rdata_valid[1] with req_done[1].
- Missed ACK twice then success, MAX_RETRY=3 -> three seq strobes, one accept, stat_retry_cnt=2, error=0.
- Missed ACK on all four attempts -> req_error=1, stat_retry_cnt=3, stat_error_cnt=1.
- Arbitration, NUM_REQ=3, all requesting continuously, init_active=0 -> grants 1,2,0,1. With init_active=1 only requester 0 is granted; req1 waits and is granted after init_active falls.
- Faults and reset:
  - seq_busy never rises -> error after START_TO.
  - busy stuck high -> error at TIMEOUT_CYC.
  - reset mid-WAIT_DONE -> all outputs 0 immediately.

Source files
------------

// File: rtl/codec_ctrl_pkg.sv
// Shared types and helpers for the CODEC control arbiter: FSM states, operation codes
// and saturating statistics arithmetic.
package codec_ctrl_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } op_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester strictly after
// the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         mask,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic int wrap(input int p, input int i);
        return (p + i) % NUM_REQ;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Offset 1..NUM_REQ so the last-granted requester is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any && req[wrap(int'(ptr), i)] && mask[wrap(int'(ptr), i)]) begin
                any                      = 1'b1;
                grant[wrap(int'(ptr), i)] = 1'b1;
                idx                      = IDX_W'(wrap(int'(ptr), i));
            end
        end
    end

endmodule

// File: rtl/codec_ctrl_arbiter.sv
// Multi-requester front end for the CODEC register sequencer: arbitrates, issues one
// transaction at a time, retries on missed ACK, aborts on timeout and keeps statistics.
module codec_ctrl_arbiter
    import codec_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_RETRY   = 3,
    parameter int START_TO    = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_active,
    input  logic [NUM_REQ-1:0]        req_rd_en,
    input  logic [NUM_REQ-1:0]        req_wr_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_error,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_rdata_valid,
    output logic                      seq_rd_en,
    output logic                      seq_wr_en,
    output logic [ADDR_W-1:0]         seq_addr,
    output logic [DATA_W-1:0]         seq_wdata,
    input  logic [DATA_W-1:0]         seq_rdata,
    input  logic                      seq_rdata_valid,
    input  logic                      seq_busy,
    input  logic                      seq_missed_ack,
    output logic                      busy,
    output logic [STAT_W-1:0]         stat_retry_cnt,
    output logic [STAT_W-1:0]         stat_error_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ST_W  = $clog2(START_TO + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 2);

    state_t             state;
    op_t                op;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;
    logic [DATA_W-1:0]  rd_buf;
    logic [RT_W-1:0]    retry_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [ST_W-1:0]    st_cnt;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               to_hit;
    logic               st_hit;
    logic               fin;
    logic               fin_err;
    logic               do_retry;
    logic               cap_rd;
    logic               cap_wr;

    assign elig   = init_active ? NUM_REQ'(1) : {NUM_REQ{1'b1}};
    assign busy   = (state != IDLE);
    assign to_hit = (to_cnt >= TO_W'(TIMEOUT_CYC - 1));
    assign st_hit = (st_cnt >= ST_W'(START_TO - 1));
    assign cap_rd = req_rd_en[arb_idx];
    assign cap_wr = req_wr_en[arb_idx];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_rd_en | req_wr_en),
        .mask  (elig),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Decide when the current transaction finishes, and whether it failed or retries.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        do_retry = 1'b0;
        case (state)
            ISSUE: begin
                if (op == OP_BAD) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WAIT_START: begin
                if (to_hit || (!seq_busy && st_hit)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!seq_busy) begin
                    if (seq_missed_ack && (retry_cnt < RT_W'(MAX_RETRY))) begin
                        do_retry = 1'b1;
                    end else begin
                        fin     = 1'b1;
                        fin_err = seq_missed_ack;
                    end
                end else if (to_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            op              <= OP_RD;
            gidx            <= '0;
            ptr             <= '0;
            rd_buf          <= '0;
            retry_cnt       <= '0;
            to_cnt          <= '0;
            st_cnt          <= '0;
            req_accept      <= '0;
            req_done        <= '0;
            req_error       <= '0;
            req_rdata       <= '0;
            req_rdata_valid <= '0;
            seq_rd_en       <= 1'b0;
            seq_wr_en       <= 1'b0;
            seq_addr        <= '0;
            seq_wdata       <= '0;
            stat_retry_cnt  <= '0;
            stat_error_cnt  <= '0;
        end else begin
            req_accept      <= '0;
            req_done        <= '0;
            req_error       <= '0;
            req_rdata_valid <= '0;
            seq_rd_en       <= 1'b0;
            seq_wr_en       <= 1'b0;

            if (state == WAIT_DONE && seq_rdata_valid) rd_buf <= seq_rdata;
            if (state == ISSUE || state == WAIT_START || state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gidx       <= arb_idx;
                        seq_addr   <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        seq_wdata  <= req_wdata[arb_idx*DATA_W +: DATA_W];
                        op         <= (cap_rd && cap_wr) ? OP_BAD : (cap_rd ? OP_RD : OP_WR);
                        req_accept <= arb_grant;
                        seq_rd_en  <= cap_rd && !cap_wr;
                        seq_wr_en  <= cap_wr && !cap_rd;
                        to_cnt     <= '0;
                        retry_cnt  <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    st_cnt <= '0;
                    state  <= WAIT_START;
                end
                WAIT_START: begin
                    if (seq_busy) state <= WAIT_DONE;
                    else st_cnt <= st_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (do_retry) begin
                        retry_cnt      <= retry_cnt + 1'b1;
                        stat_retry_cnt <= sat_inc(stat_retry_cnt);
                        seq_rd_en      <= (op == OP_RD);
                        seq_wr_en      <= (op == OP_WR);
                        state          <= ISSUE;
                    end
                end
                RESP: begin
                    ptr   <= gidx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Completion overrides the per-state next state above.
            if (fin) begin
                state           <= RESP;
                req_done[gidx]  <= 1'b1;
                req_error[gidx] <= fin_err;
                if (fin_err) begin
                    stat_error_cnt <= sat_inc(stat_error_cnt);
                end else if (op == OP_RD) begin
                    req_rdata_valid[gidx] <= 1'b1;
                    req_rdata             <= seq_rdata_valid ? seq_rdata : rd_buf;
                end
            end
        end
    end

endmodule
